// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences operand reads, result capture and write-back for a banked MAC datapath.
// Optional cycle counter enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_seq_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int BANK_STRIDE = 1024,
    parameter int BANKS       = 4,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [15:0]       iter_num,
    input  logic [7:0]        acc_num,
    input  logic [1:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycle_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              op_valid,
    output logic              op_last,
    output logic [1:0]        phase_o,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [15:0] iter_q, k;
    logic [7:0] acc_q, j, b;
    logic [DATA_W-1:0] res_q;
    logic [RD_LAT-1:0] ov_sr, ol_sr;
    logic accept, j_last, k_last, b_last;

    // State register; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_n;

    // Next state and all strobes/addresses, gated to zero outside their state.
    always_comb begin
        accept  = (state == IDLE) && start;
        j_last  = j == acc_q - 8'd1;
        k_last  = k == iter_q - 16'd1;
        b_last  = b == 8'(BANKS - 1);
        busy    = (state == ISSUE) || (state == WAIT) || (state == WRITE);
        done    = state == DONE;
        rd_en   = state == ISSUE;
        wr_en   = state == WRITE;
        a_addr  = rd_en ? ADDR_W'(32'(b) * 32'(BANK_STRIDE) + 32'(j)) : '0;
        b_addr  = rd_en ? ADDR_W'(32'(k) * 32'(acc_q) + 32'(j)) : '0;
        wr_addr = wr_en ? ADDR_W'(32'(b) * 32'(BANK_STRIDE) + 32'(k)) : '0;
        wr_data = wr_en ? res_q : '0;
        op_valid = ov_sr[RD_LAT-1];
        op_last  = ol_sr[RD_LAT-1];
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (iter_num == 16'd0 || acc_num == 8'd0) ? DONE : ISSUE;
            ISSUE:   if (j_last) state_n = WAIT;
            WAIT:    if (res_valid) state_n = WRITE;
            WRITE:   state_n = (k_last && b_last) ? DONE : ISSUE;
            DONE:    if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Run parameters, loop indices, result capture, sticky error and the read-latency delay line.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            iter_q  <= '0;
            acc_q   <= '0;
            phase_o <= '0;
            err     <= 1'b0;
            b       <= '0;
            k       <= '0;
            j       <= '0;
            res_q   <= '0;
            ov_sr   <= '0;
            ol_sr   <= '0;
        end else begin
            ov_sr <= RD_LAT'({ov_sr, rd_en});
            ol_sr <= RD_LAT'({ol_sr, rd_en && j_last});
            if (accept) begin
                iter_q  <= iter_num;
                acc_q   <= acc_num;
                phase_o <= phase;
                err     <= 1'b0;
                b       <= '0;
                k       <= '0;
                j       <= '0;
            end else if (res_valid && state != WAIT) err <= 1'b1;
            if (rd_en) j <= j_last ? '0 : j + 8'd1;
            if (state == WAIT && res_valid) res_q <= res_data;
            if (wr_en) begin
                k <= k_last ? '0 : k + 16'd1;
                if (k_last) b <= b + 8'd1;
            end
        end

`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Busy-cycle counter: cleared on start acceptance, saturating, held after the run.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else if (accept) cnt_q <= '0;
        else if (busy && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif
endmodule
